mp_sram_reg_rd: RTL

- Parametrised multi-ported register-file SRAM with one-hot (decoded) addresses. It is the next generation of the 10R5W pipe-stage SRAM.
- Read and write port counts are parameters. Read data is registered (1-cycle latency) with an optional same-cycle write-to-read bypass.
- Adds deterministic write-port priority, conflict and address-error flags, and a configurable reset initialisation range and mode.
- Used for rename/free-list/PRF-style tables in the core pipeline.

---
 rtl/mp_sram_pkg.sv | 27 ++
 rtl/mp_sram_rd_port.sv | 65 ++++++
 rtl/mp_sram_reg_rd.sv | 113 +++++++++++
 3 files changed

// File: rtl/mp_sram_pkg.sv
// rtl/mp_sram_pkg.sv - shared helpers for the multi-ported one-hot register-file SRAM
package mp_sram_pkg;

  localparam int INIT_ZERO  = 0;
  localparam int INIT_INDEX = 1;

  // Widest address vector the one-hot checker accepts; narrower vectors are zero-extended.
  localparam int MAX_DEPTH = 4096;

  function automatic int slice_lo(input int port, input int width);
    return port * width;
  endfunction

  function automatic int slice_hi(input int port, input int width);
    return port * width + width - 1;
  endfunction

  // Returns {zero, multi} for a decoded address.
  function automatic logic [1:0] onehot_check(input logic [MAX_DEPTH-1:0] vec);
    logic zero;
    logic multi;
    zero  = (vec == '0);
    multi = ((vec & (vec - MAX_DEPTH'(1))) != '0);
    return {zero, multi};
  endfunction

endpackage

// File: rtl/mp_sram_rd_port.sv
// rtl/mp_sram_rd_port.sv - one registered read port with highest-index select and write bypass
module mp_sram_rd_port
  import mp_sram_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int WIDTH  = 8,
  parameter int NWR    = 5,
  parameter int BYPASS = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rd_en,
  input  logic [DEPTH-1:0]       rd_addr,
  input  logic [DEPTH*WIDTH-1:0] mem_flat,
  input  logic [NWR-1:0]         wr_en,
  input  logic [NWR*DEPTH-1:0]   wr_addr,
  input  logic [NWR*WIDTH-1:0]   wr_data,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   rd_valid,
  output logic [DEPTH-1:0]       rd_addr_q,
  output logic                   addr_bad
);

  logic             sel_hit;
  int               sel_idx;
  logic [WIDTH-1:0] next_data;

  always_comb begin
    sel_hit   = 1'b0;
    sel_idx   = 0;
    next_data = '0;
    for (int e = 0; e < DEPTH; e++) begin
      if (rd_addr[e]) begin
        sel_hit = 1'b1;
        sel_idx = e;
      end
    end
    if (sel_hit) begin
      next_data = mem_flat[slice_lo(sel_idx, WIDTH) +: WIDTH];
      // Ascending scan so the highest-numbered write port's data is what remains.
      if (BYPASS != 0) begin
        for (int k = 0; k < NWR; k++) begin
          if (wr_en[k] && wr_addr[slice_lo(k, DEPTH) + sel_idx]) begin
            next_data = wr_data[slice_lo(k, WIDTH) +: WIDTH];
          end
        end
      end
    end
  end

  assign addr_bad = rd_en && (onehot_check(MAX_DEPTH'(rd_addr)) != 2'b00);

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      rd_addr_q <= '0;
    end else begin
      rd_data   <= rd_en ? next_data : '0;
      rd_valid  <= rd_en;
      rd_addr_q <= rd_addr;
    end
  end

endmodule

// File: rtl/mp_sram_reg_rd.sv
// rtl/mp_sram_reg_rd.sv - parametrised NRD-read NWR-write one-hot addressed register-file SRAM
module mp_sram_reg_rd
  import mp_sram_pkg::*;
#(
  parameter int DEPTH     = 64,
  parameter int WIDTH     = 8,
  parameter int NRD       = 10,
  parameter int NWR       = 5,
  parameter int RST_LO    = 0,
  parameter int INIT_MODE = INIT_ZERO,
  parameter int BYPASS    = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NRD-1:0]         rd_en_i,
  input  logic [NRD*DEPTH-1:0]   rd_addr_i,
  input  logic [NWR-1:0]         wr_en_i,
  input  logic [NWR*DEPTH-1:0]   wr_addr_i,
  input  logic [NWR*WIDTH-1:0]   wr_data_i,
  output logic [NRD*WIDTH-1:0]   rd_data_o,
  output logic [NRD-1:0]         rd_valid_o,
  output logic [NRD*DEPTH-1:0]   rd_addr_o,
  output logic                   wr_conflict_o,
  output logic                   addr_err_o
);

  logic [WIDTH-1:0]       mem [DEPTH];
  logic [DEPTH*WIDTH-1:0] mem_flat;
  logic [NRD-1:0]         rd_bad;
  logic                   wr_bad;
  logic                   conflict;
  logic                   seen;

  // Later ports overwrite earlier ones in the same edge, giving highest-port priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int e = 0; e < DEPTH; e++) begin
        if (e >= RST_LO) begin
          mem[e] <= (INIT_MODE == INIT_INDEX) ? WIDTH'(e) : '0;
        end
      end
    end else begin
      for (int k = 0; k < NWR; k++) begin
        for (int e = 0; e < DEPTH; e++) begin
          if (wr_en_i[k] && wr_addr_i[slice_lo(k, DEPTH) + e]) begin
            mem[e] <= wr_data_i[slice_lo(k, WIDTH) +: WIDTH];
          end
        end
      end
    end
  end

  always_comb begin
    mem_flat = '0;
    for (int e = 0; e < DEPTH; e++) begin
      mem_flat[slice_lo(e, WIDTH) +: WIDTH] = mem[e];
    end
  end

  always_comb begin
    conflict = 1'b0;
    wr_bad   = 1'b0;
    seen     = 1'b0;
    for (int e = 0; e < DEPTH; e++) begin
      seen = 1'b0;
      for (int k = 0; k < NWR; k++) begin
        if (wr_en_i[k] && wr_addr_i[slice_lo(k, DEPTH) + e]) begin
          if (seen) conflict = 1'b1;
          seen = 1'b1;
        end
      end
    end
    for (int k = 0; k < NWR; k++) begin
      if (wr_en_i[k] &&
          (onehot_check(MAX_DEPTH'(wr_addr_i[slice_lo(k, DEPTH) +: DEPTH])) != 2'b00)) begin
        wr_bad = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_conflict_o <= 1'b0;
      addr_err_o    <= 1'b0;
    end else begin
      wr_conflict_o <= conflict;
      addr_err_o    <= wr_bad | (|rd_bad);
    end
  end

  for (genvar r = 0; r < NRD; r++) begin : g_rd
    mp_sram_rd_port #(
      .DEPTH  (DEPTH),
      .WIDTH  (WIDTH),
      .NWR    (NWR),
      .BYPASS (BYPASS)
    ) u_port (
      .clk       (clk),
      .reset     (reset),
      .rd_en     (rd_en_i[r]),
      .rd_addr   (rd_addr_i[r*DEPTH +: DEPTH]),
      .mem_flat  (mem_flat),
      .wr_en     (wr_en_i),
      .wr_addr   (wr_addr_i),
      .wr_data   (wr_data_i),
      .rd_data   (rd_data_o[r*WIDTH +: WIDTH]),
      .rd_valid  (rd_valid_o[r]),
      .rd_addr_q (rd_addr_o[r*DEPTH +: DEPTH]),
      .addr_bad  (rd_bad[r])
    );
  end

endmodule
